// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing generator advancing on pixel-clock enables.
// Define VGA_TIMING_PREFETCH_EN to enable the line_prefetch_o strobe; otherwise it is tied to 0.
package vga_timing_pkg;
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
    logic end_of_line;
    logic end_of_frame;
  } VGA_Timing;
endpackage

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CNT_W     = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_ce_i,
  output VGA_Timing        timing_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic [15:0]      frame_cnt_o,
  output logic             line_prefetch_o
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  if (H_SYNC == 0 || V_SYNC == 0 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
    $error("vga_timing_gen: illegal geometry parameters");
  end
  // Compare in CNT_W+1 bits so region ends equal to 2^CNT_W stay representable.
  localparam logic [CNT_W:0] H_VIS = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] H_SB  = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] H_SE  = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] H_LST = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_VIS = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] V_SB  = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] V_SE  = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W:0] V_LST = (CNT_W+1)'(V_TOTAL - 1);
  localparam VGA_Timing T_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0, end_of_line: 1'b0, end_of_frame: 1'b0};
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W:0] h_ext, v_ext;
  logic h_last, v_last, h_sync, v_sync, h_vis, v_vis;
  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_last = h_ext == H_LST;
  assign v_last = v_ext == V_LST;
  assign h_sync = h_ext >= H_SB && h_ext < H_SE;
  assign v_sync = v_ext >= V_SB && v_ext < V_SE;
  assign h_vis  = h_ext < H_VIS;
  assign v_vis  = v_ext < V_VIS;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x_o         <= '0;
      y_o         <= '0;
      frame_cnt_o <= '0;
      timing_o    <= T_RST;
    end else if (pix_ce_i) begin
      timing_o <= '{hsync_n: !h_sync, vsync_n: !v_sync, blank_n: h_vis && v_vis,
                    end_of_line: h_last, end_of_frame: h_last && v_last};
      x_o      <= h_cnt;
      y_o      <= v_cnt;
      h_cnt    <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      if (h_last && v_last) frame_cnt_o <= frame_cnt_o + 16'd1;
    end else begin
      timing_o.end_of_line  <= 1'b0;
      timing_o.end_of_frame <= 1'b0;
    end
`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] v_next;
  assign v_next = v_last ? '0 : v_cnt + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) line_prefetch_o <= 1'b0;
    else line_prefetch_o <= pix_ce_i && h_last && ({1'b0, v_next} < V_VIS);
`else
  assign line_prefetch_o = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced 16x10 raster.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;
  localparam int HV = 8, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int CW = 5;
`ifdef VGA_TIMING_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  typedef struct {int hs, vs, bl, eol, eof, x, y, f, pf;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
  VGA_Timing timing;
  logic [CW-1:0] x, y;
  logic [15:0] frame_cnt;
  logic line_prefetch;
  int n_vec = 0, n_err = 0;
  int mh, mv, mf;
  exp_t le;
  exp_t q[$];
  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(ce), .timing_o(timing),
    .x_o(x), .y_o(y), .frame_cnt_o(frame_cnt), .line_prefetch_o(line_prefetch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mh = 0; mv = 0; mf = 0;
    le = '{hs: 1, vs: 1, bl: 0, eol: 0, eof: 0, x: 0, y: 0, f: 0, pf: 0};
    q.delete();
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_hsync"}, timing.hsync_n, 1);
    chk({tag, "_vsync"}, timing.vsync_n, 1);
    chk({tag, "_blank"}, timing.blank_n, 0);
    chk({tag, "_eol"}, timing.end_of_line, 0);
    chk({tag, "_eof"}, timing.end_of_frame, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_frame"}, frame_cnt, 0);
    chk({tag, "_pf"}, line_prefetch, 0);
  endtask
  // Called at a negedge: drives ce, queues the expected result, checks it after the next posedge.
  task automatic step(input bit c);
    exp_t e;
    int nv;
    ce = c;
    if (c) begin
      e.hs  = !(mh >= HV + HF && mh < HV + HF + HS);
      e.vs  = !(mv >= VV + VF && mv < VV + VF + VS);
      e.bl  = mh < HV && mv < VV;
      e.eol = mh == HT - 1;
      e.eof = e.eol && mv == VT - 1;
      e.x   = mh;
      e.y   = mv;
      nv    = (mv == VT - 1) ? 0 : mv + 1;
      e.pf  = PF && e.eol && nv < VV;
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          mf = (mf + 1) & 16'hffff;
        end else mv++;
      end else mh++;
      e.f = mf;
    end else begin
      e = le;
      e.eol = 0;
      e.eof = 0;
      e.pf  = 0;
    end
    le = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("hsync", timing.hsync_n, e.hs);
    chk("vsync", timing.vsync_n, e.vs);
    chk("blank", timing.blank_n, e.bl);
    chk("eol", timing.end_of_line, e.eol);
    chk("eof", timing.end_of_frame, e.eof);
    chk("x", x, e.x);
    chk("y", y, e.y);
    chk("frame", frame_cnt, e.f);
    chk("prefetch", line_prefetch, e.pf);
    @(negedge clk);
  endtask
  initial begin
    int first_eol = 0, first_eof = 0, f_at_eof = -1, bl_run = 0, hs_start = 0, vs_low = 0;
    int pf_cnt = 0, pf_last = 0, pf_vis_end = 0, eol_a = 0, eol_b = 0, found = 0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= HT * VT; c++) begin
      step(1);
      if (timing.end_of_line && first_eol == 0) first_eol = c;
      if (timing.end_of_frame && first_eof == 0) begin
        first_eof = c;
        f_at_eof = frame_cnt;
      end
      if (c <= HT && timing.blank_n) bl_run++;
      if (c <= HT && !timing.hsync_n && hs_start == 0) hs_start = c;
      if (!timing.vsync_n) vs_low++;
      if (line_prefetch) begin
        pf_cnt++;
        if (y == CW'(VT - 1)) pf_last++;
        if (y == CW'(VV - 1)) pf_vis_end++;
      end
    end
    chk("first_eol_clock", first_eol, HT);
    chk("first_eof_clock", first_eof, HT * VT);
    chk("frame_at_eof", f_at_eof, 1);
    chk("blank_run", bl_run, HV);
    chk("hsync_start", hs_start, 1 + HV + HF);
    chk("vsync_low_clocks", vs_low, VS * HT);
    chk("prefetch_per_frame", pf_cnt, PF ? VV : 0);
    chk("prefetch_last_line", pf_last, PF ? 1 : 0);
    chk("prefetch_vis_end", pf_vis_end, 0);
    for (int c = 1; c <= 5 * HT; c++) begin
      step(c % 2);
      if (timing.end_of_line) begin
        if (eol_a == 0) eol_a = c;
        else if (eol_b == 0) eol_b = c;
      end
    end
    chk("ce_eol_period", eol_b - eol_a, 2 * HT);
    for (int c = 0; c < 2 * HT * VT && !found; c++) begin
      step(1);
      found = (x == CW'(5) && y == CW'(3));
    end
    chk("mid_frame_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("restart_x", x, 0);
    chk("restart_y", y, 0);
    chk("restart_blank", timing.blank_n, 1);
    repeat (2 * HT) step(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
